toggle_gen: RTL
===============

TOGGLE_GEN -- requirements
Module: toggle_gen

Interface
REQ-001 LFSR_SEED, 32'hACE1_0001, reset/start seed of the LFSR; a value of 0 is illegal and shall be flagged by an elaboration assertion.
REQ-002 LFSR_MASK, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  single-cycle request to begin a run.
REQ-006 stop  in  1  single-cycle request to end a run.
REQ-007 mode  in  2  pattern: 0 constant low, 1 square wave, 2 raw LFSR bit, 3 rate-thresholded LFSR toggle.
REQ-008 half_period  in  8  square-wave half period minus one.
REQ-009 rate  in  8  mode-3 toggle threshold, out of 256.
REQ-010 burst_len  in  16  run length in cycles; 0 = continuous.
REQ-011 toggle_change  out  1  registered stimulus bit to the downstream test unit.
REQ-012 busy  out  1  high while in RUN.
REQ-013 done  out  1  one-cycle pulse on run end.
REQ-014 toggle_cnt  out  32  transitions of toggle_change in the current or last run.

Function
REQ-015 FSM states IDLE, RUN, DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-016 IDLE->RUN on start; mode, half_period, rate and burst_len are latched at that edge; the LFSR is reloaded with LFSR_SEED; toggle_cnt, burst counter and half-period counter are cleared.
REQ-017 start in RUN or DONE is ignored; stop in IDLE or DONE is ignored; start and stop together in IDLE are treated as start.
REQ-018 RUN->DONE on stop or when the burst counter reaches latched burst_len (burst_len != 0); both events in the same cycle produce one DONE.
REQ-019 With burst_len = N > 0, exactly N RUN cycles occur; busy is high N cycles, and done asserts on the cycle after the last RUN cycle.
REQ-020 The first toggle_change update occurs at the first RUN edge, one cycle after start is sampled.
REQ-021 The LFSR advances once per RUN cycle only; it holds in IDLE and DONE.
REQ-022 Mode 0: toggle_change = 0.
REQ-023 Mode 1: toggle_change inverts every (half_period+1) RUN cycles; half_period = 0 inverts every cycle.
REQ-024 Mode 2: toggle_change = LFSR bit 0 after advance.
REQ-025 Mode 3: toggle_change inverts when LFSR[7:0] < rate; rate 0 never toggles.
REQ-026 toggle_change is forced to 0 on entering DONE and held at 0 in IDLE.
REQ-027 toggle_cnt increments on each RUN-cycle change of toggle_change and saturates at 32'hFFFF_FFFF; the forced-0 change on entering DONE is not counted.
REQ-028 toggle_cnt holds its value through DONE and IDLE until the next start.
REQ-029 The burst counter is 16-bit and never wraps; in continuous mode it is not compared.

Reset
REQ-030 rst forces IDLE, toggle_change=0, busy=0, done=0, toggle_cnt=0, LFSR=LFSR_SEED and all counters to 0, and clears latched config.
REQ-031 rst mid-run aborts immediately, with no done pulse; the first start after release behaves as a fresh run.

Structure
REQ-032 Package toggle_gen_pkg holds the mode encoding, FSM state type and default LFSR_SEED/LFSR_MASK constants.
REQ-033 Sub-module toggle_gen_lfsr, a 32-bit Galois LFSR with load and advance inputs, shall be instantiated once.
REQ-034 Every output shall be driven from a flop.

Verification
REQ-035 mode=1, half_period=2, burst_len=12, start -> toggle_change 000111000111 over 12 cycles; toggle_cnt=3; done 13 cycles after start.
REQ-036 mode=3, rate=0, burst_len=100 -> toggle_change stays 0, toggle_cnt=0; with rate=255 -> toggle_cnt within 5% of 100*255/256.
REQ-037 mode=2, burst_len=0, stop after 1000 cycles -> output matches the reference LFSR model bit-for-bit; done one cycle after stop.
REQ-038 start during RUN and stop during IDLE -> no state change; start+stop together in IDLE -> run begins.
REQ-039 rst asserted 5 cycles into a 50-cycle burst -> all outputs 0 asynchronously, no done; the next run reproduces the identical sequence from seed.
REQ-040 stop in the final burst cycle -> a single done pulse, and toggle_cnt matches the model.

Source files
------------

// File: rtl/toggle_gen_pkg.sv
// Shared types and constants for the toggle stimulus generator.
//   mode_e    : pattern selection encoding
//   state_e   : run-control FSM states
//   cfg_t     : run configuration captured at start
//   lfsr_step : one Galois step of the 32-bit LFSR
package toggle_gen_pkg;

    localparam int unsigned LFSR_W  = 32;
    localparam int unsigned HP_W    = 8;
    localparam int unsigned RATE_W  = 8;
    localparam int unsigned BURST_W = 16;
    localparam int unsigned CNT_W   = 32;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 32'hACE1_0001;
    localparam logic [LFSR_W-1:0] LFSR_MASK_DEF = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_LOW    = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_RATE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        mode_e               mode;
        logic [HP_W-1:0]     half_period;
        logic [RATE_W-1:0]   rate;
        logic [BURST_W-1:0]  burst_len;
    } cfg_t;

    // Right-shifting Galois step: the bit shifted out selects the feedback mask.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q,
                                                    input logic [LFSR_W-1:0] mask);
        return (q >> 1) ^ (q[0] ? mask : {LFSR_W{1'b0}});
    endfunction

endpackage

// File: rtl/toggle_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous load and advance.
//   clk, rst      : clock, async active-high reset (resets to SEED)
//   load          : reload SEED (has priority over advance)
//   advance       : take one LFSR step
//   next_low_c    : low byte of the value the next advance will produce
module toggle_gen_lfsr
    import toggle_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF,
    parameter logic [LFSR_W-1:0] MASK = LFSR_MASK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [7:0]       next_low_c
);

    logic [LFSR_W-1:0] q;
    logic [LFSR_W-1:0] q_next;

    assign q_next     = lfsr_step(q, MASK);
    assign next_low_c = q_next[7:0];

    // LFSR state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (advance) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/toggle_gen.sv
// Toggle stimulus generator: emits a constant, square-wave, raw-LFSR or
// rate-thresholded LFSR toggle pattern for a bounded or continuous run.
//   clk, rst        : clock, async active-high reset
//   start, stop     : single-cycle run begin / end requests
//   mode            : 0 low, 1 square, 2 raw LFSR bit, 3 rate toggle
//   half_period     : square-wave half period minus one
//   rate            : mode-3 toggle threshold out of 256
//   burst_len       : run length in cycles, 0 = continuous
//   toggle_change   : registered stimulus bit
//   busy            : high while running
//   done            : one-cycle pulse when a run ends
//   toggle_cnt      : transitions of toggle_change in the current/last run
module toggle_gen
    import toggle_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter logic [LFSR_W-1:0] LFSR_MASK = LFSR_MASK_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [HP_W-1:0]     half_period,
    input  logic [RATE_W-1:0]   rate,
    input  logic [BURST_W-1:0]  burst_len,
    output logic                toggle_change,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    toggle_cnt
);

    // An all-zero seed locks the LFSR at zero.
    if (LFSR_SEED == {LFSR_W{1'b0}}) begin : g_seed_check
        $error("toggle_gen: LFSR_SEED must be non-zero");
    end

    state_e               state_q;
    state_e               state_d;
    cfg_t                 cfg_q;
    cfg_t                 cfg_d;
    logic [BURST_W-1:0]   bcnt_q;
    logic [BURST_W-1:0]   bcnt_d;
    logic [HP_W-1:0]      hpcnt_q;
    logic [HP_W-1:0]      hpcnt_d;
    logic                 tog_d;
    logic                 busy_d;
    logic                 done_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 lfsr_load_c;
    logic                 lfsr_adv_c;
    logic [7:0]           lfsr_next_low_c;
    logic                 last_c;

    toggle_gen_lfsr #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load_c),
        .advance    (lfsr_adv_c),
        .next_low_c (lfsr_next_low_c)
    );

    // Current RUN cycle is the last one of a bounded burst.
    assign last_c = (cfg_q.burst_len != {BURST_W{1'b0}}) &&
                    (bcnt_q == cfg_q.burst_len - BURST_W'(1));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '0;
            bcnt_q        <= '0;
            hpcnt_q       <= '0;
            toggle_change <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            toggle_cnt    <= '0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            bcnt_q        <= bcnt_d;
            hpcnt_q       <= hpcnt_d;
            toggle_change <= tog_d;
            busy          <= busy_d;
            done          <= done_d;
            toggle_cnt    <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (stop || last_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cfg_d       = cfg_q;
        bcnt_d      = bcnt_q;
        hpcnt_d     = hpcnt_q;
        tog_d       = toggle_change;
        cnt_d       = toggle_cnt;
        lfsr_load_c = 1'b0;
        lfsr_adv_c  = 1'b0;
        busy_d      = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                tog_d = 1'b0;
                if (start) begin
                    cfg_d.mode        = mode_e'(mode);
                    cfg_d.half_period = half_period;
                    cfg_d.rate        = rate;
                    cfg_d.burst_len   = burst_len;
                    bcnt_d            = '0;
                    hpcnt_d           = '0;
                    cnt_d             = '0;
                    lfsr_load_c       = 1'b1;
                end
            end
            ST_RUN: begin
                lfsr_adv_c = 1'b1;
                // Saturate rather than wrap in continuous runs.
                if (bcnt_q != {BURST_W{1'b1}}) bcnt_d = bcnt_q + BURST_W'(1);

                case (cfg_q.mode)
                    MODE_LOW:    tog_d = 1'b0;
                    MODE_SQUARE: begin
                        if (hpcnt_q == cfg_q.half_period) begin
                            tog_d   = ~toggle_change;
                            hpcnt_d = '0;
                        end else begin
                            hpcnt_d = hpcnt_q + HP_W'(1);
                        end
                    end
                    MODE_LFSR:   tog_d = lfsr_next_low_c[0];
                    MODE_RATE:   if (lfsr_next_low_c < cfg_q.rate) tog_d = ~toggle_change;
                    default:     tog_d = 1'b0;
                endcase

                // The forced return to 0 at run end is not a counted transition.
                if (state_d == ST_DONE) begin
                    tog_d = 1'b0;
                end else if ((tog_d != toggle_change) && (toggle_cnt != {CNT_W{1'b1}})) begin
                    cnt_d = toggle_cnt + CNT_W'(1);
                end
            end
            ST_DONE: tog_d = 1'b0;
            default: tog_d = 1'b0;
        endcase
    end

endmodule
